// File: rtl/pipe_core_param.sv
// rtl/pipe_core_param.sv - parameterised 4-stage IF/ID/EX/WB integer pipeline
// Forwarding from WB, branch flush in EX, data-memory handshake with stall, HALT and retire count.
module pipe_core_param #(
  parameter int              DW       = 32,
  parameter int              NREG     = 32,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic [DW-1:0]   dmem_rdata,
  input  logic            dmem_ack,
  output logic            halted,
  output logic [31:0]     retired,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [DW-1:0]   wb_data
);

  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_ADDI = 6'd7;
  localparam logic [5:0] OP_LW   = 6'd8;
  localparam logic [5:0] OP_SW   = 6'd9;
  localparam logic [5:0] OP_BEQ  = 6'd10;
  localparam logic [5:0] OP_HALT = 6'd11;

  function automatic logic [4:0] map_reg(input logic [4:0] f);
    return (int'(f) < NREG) ? f : 5'd0;
  endfunction

  logic [DW-1:0]   rf [NREG];
  logic [PC_W-1:0] pc;
  logic            fetch_stop;

  logic            ifid_valid;
  logic [31:0]     ifid_instr;
  logic [PC_W-1:0] ifid_pc;

  logic            idex_valid;
  logic [5:0]      idex_op;
  logic [4:0]      idex_rs1, idex_rs2, idex_rd;
  logic            idex_we;
  logic [DW-1:0]   idex_a, idex_b;
  logic [15:0]     idex_imm;
  logic [PC_W-1:0] idex_pc;

  logic            exwb_valid;
  logic            exwb_we;
  logic            exwb_halt;
  logic [4:0]      exwb_rd;
  logic [DW-1:0]   exwb_data;

  logic [5:0]      id_op;
  logic [4:0]      id_rs1, id_rs2, id_rdr, id_dst;
  logic            id_wr;
  logic [DW-1:0]   id_a, id_b;

  logic [DW-1:0]   fwd_a, fwd_b, imm_x, ex_res;
  logic            mem_op, stall, br_taken, ex_halt;
  logic [PC_W-1:0] br_target;

  assign id_op  = ifid_instr[31:26];
  assign id_rs1 = map_reg(ifid_instr[25:21]);
  assign id_rs2 = map_reg(ifid_instr[20:16]);
  assign id_rdr = map_reg(ifid_instr[15:11]);
  // Immediate-format ops overlap rd with imm, so their destination is the rs2 field.
  assign id_dst = (id_op == OP_ADDI || id_op == OP_LW) ? id_rs2 : id_rdr;
  assign id_wr  = (id_op >= OP_ADD) && (id_op <= OP_LW);

  // Register read with write-through of the result retiring this cycle.
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs1 != 5'd0)
      id_a = (exwb_valid && exwb_we && exwb_rd == id_rs1) ? exwb_data : rf[id_rs1[AW-1:0]];
    if (id_rs2 != 5'd0)
      id_b = (exwb_valid && exwb_we && exwb_rd == id_rs2) ? exwb_data : rf[id_rs2[AW-1:0]];
  end

  assign fwd_a = (exwb_valid && exwb_we && exwb_rd == idex_rs1 && idex_rs1 != 5'd0) ? exwb_data : idex_a;
  assign fwd_b = (exwb_valid && exwb_we && exwb_rd == idex_rs2 && idex_rs2 != 5'd0) ? exwb_data : idex_b;
  assign imm_x = DW'($signed(idex_imm));

  assign mem_op    = idex_valid && (idex_op == OP_LW || idex_op == OP_SW);
  assign stall     = mem_op && !dmem_ack;
  assign br_taken  = idex_valid && (idex_op == OP_BEQ) && (fwd_a == fwd_b);
  assign br_target = idex_pc + PC_W'(1) + PC_W'($signed(idex_imm));
  assign ex_halt   = idex_valid && (idex_op == OP_HALT);

  always_comb begin
    ex_res = '0;
    case (idex_op)
      OP_ADD:  ex_res = fwd_a + fwd_b;
      OP_SUB:  ex_res = fwd_a - fwd_b;
      OP_AND:  ex_res = fwd_a & fwd_b;
      OP_OR:   ex_res = fwd_a | fwd_b;
      OP_XOR:  ex_res = fwd_a ^ fwd_b;
      OP_SLT:  ex_res = DW'($signed(fwd_a) < $signed(fwd_b));
      OP_ADDI: ex_res = fwd_a + imm_x;
      OP_LW:   ex_res = dmem_rdata;
      default: ex_res = '0;
    endcase
  end

  assign imem_addr  = pc;
  assign dmem_req   = mem_op;
  assign dmem_we    = mem_op && (idex_op == OP_SW);
  assign dmem_addr  = mem_op ? (fwd_a + imm_x) : '0;
  assign dmem_wdata = (mem_op && idex_op == OP_SW) ? fwd_b : '0;
  assign wb_valid   = exwb_valid && exwb_we;
  assign wb_rd      = exwb_rd;
  assign wb_data    = exwb_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      fetch_stop <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      idex_valid <= 1'b0;
      idex_op    <= '0;
      idex_rs1   <= '0;
      idex_rs2   <= '0;
      idex_rd    <= '0;
      idex_we    <= 1'b0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      idex_pc    <= '0;
      exwb_valid <= 1'b0;
      exwb_we    <= 1'b0;
      exwb_halt  <= 1'b0;
      exwb_rd    <= '0;
      exwb_data  <= '0;
      halted     <= 1'b0;
      retired    <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (exwb_valid) begin
        retired <= retired + 32'd1;
        if (exwb_we) rf[exwb_rd[AW-1:0]] <= exwb_data;
        if (exwb_halt) halted <= 1'b1;
      end
      if (stall) begin
        // Held EX instruction keeps its forwarded operands; WB goes idle meanwhile.
        exwb_valid <= 1'b0;
        idex_a     <= fwd_a;
        idex_b     <= fwd_b;
      end else begin
        exwb_valid <= idex_valid;
        exwb_we    <= idex_valid && idex_we;
        exwb_halt  <= ex_halt;
        exwb_rd    <= idex_rd;
        exwb_data  <= ex_res;
        if (br_taken || ex_halt || fetch_stop) begin
          ifid_valid <= 1'b0;
          idex_valid <= 1'b0;
        end else begin
          idex_valid <= ifid_valid;
          idex_op    <= id_op;
          idex_rs1   <= id_rs1;
          idex_rs2   <= id_rs2;
          idex_rd    <= id_dst;
          idex_we    <= id_wr && (id_dst != 5'd0);
          idex_a     <= id_a;
          idex_b     <= id_b;
          idex_imm   <= ifid_instr[15:0];
          idex_pc    <= ifid_pc;
          ifid_valid <= 1'b1;
          ifid_instr <= imem_data;
          ifid_pc    <= pc;
        end
        if (br_taken) pc <= br_target;
        else if (!ex_halt && !fetch_stop) pc <= pc + PC_W'(1);
        if (ex_halt) fetch_stop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_core_param.sv
// tb/tb_pipe_core_param.sv - scoreboard bench for pipe_core_param against an instruction-level model
module tb_pipe_core_param;
  localparam int          DW   = 16;
  localparam int          NREG = 16;
  localparam int          RPCI = 8;
  localparam logic [15:0] RPC  = 16'd8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic halted, wb_valid;
  logic [31:0] retired;
  logic [4:0] wb_rd;
  logic [DW-1:0] wb_data;

  pipe_core_param #(.DW(DW), .NREG(NREG), .PC_W(16), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .halted(halted), .retired(retired),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] rd; logic [DW-1:0] data; } wb_t;
  typedef struct packed { logic we; logic [DW-1:0] addr; logic [DW-1:0] wdata; } mem_t;

  logic [31:0] imem [256];
  assign imem_data = imem[imem_addr[7:0]];

  wb_t  exp_wb[$];
  mem_t exp_mem[$];
  int   wb_cyc[$];
  logic [DW-1:0] model_mem [logic [DW-1:0]];
  logic [DW-1:0] dut_mem [logic [DW-1:0]];
  int checks = 0, errors = 0;
  int cyc = 0, req_cycles = 0, exp_retired = 0, force_delay = -1, wait_cnt = 0;
  bit busy = 0;
  wb_t  w;
  mem_t m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_init(input logic [DW-1:0] a);
    return a ^ 16'h5a5a;
  endfunction

  function automatic logic [4:0] ridx(input logic [4:0] f);
    return (int'(f) < NREG) ? f : 5'd0;
  endfunction

  function automatic logic [31:0] rt(input int op, input int rd, input int rs1, input int rs2);
    return {6'(op), 5'(rs1), 5'(rs2), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] it(input int op, input int r2, input int rs1, input int imm);
    return {6'(op), 5'(rs1), 5'(r2), 16'(imm)};
  endfunction

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 6));
  endfunction

  // Architectural interpreter: one instruction at a time, no notion of stages.
  task automatic run_model();
    logic [DW-1:0] r [32];
    logic [15:0] pc, npc;
    logic [31:0] ins;
    logic [5:0] op;
    logic [4:0] s1, s2, dst;
    logic [DW-1:0] a, b, v, ad, immx;
    logic wr;
    foreach (r[i]) r[i] = '0;
    pc = RPC;
    exp_retired = 0;
    for (int steps = 0; steps < 4000; steps++) begin
      ins  = imem[pc[7:0]];
      op   = ins[31:26];
      s1   = ridx(ins[25:21]);
      s2   = ridx(ins[20:16]);
      dst  = ridx(ins[15:11]);
      a    = r[s1];
      b    = r[s2];
      immx = DW'($signed(ins[15:0]));
      v = '0; wr = 1'b0; npc = pc + 16'd1;
      exp_retired++;
      case (op)
        6'd1: begin v = a + b; wr = 1'b1; end
        6'd2: begin v = a - b; wr = 1'b1; end
        6'd3: begin v = a & b; wr = 1'b1; end
        6'd4: begin v = a | b; wr = 1'b1; end
        6'd5: begin v = a ^ b; wr = 1'b1; end
        6'd6: begin v = ($signed(a) < $signed(b)) ? 1 : 0; wr = 1'b1; end
        6'd7: begin v = a + immx; wr = 1'b1; dst = s2; end
        6'd8: begin
          ad = a + immx;
          v = model_mem.exists(ad) ? model_mem[ad] : mem_init(ad);
          wr = 1'b1; dst = s2;
          exp_mem.push_back('{we: 1'b0, addr: ad, wdata: '0});
        end
        6'd9: begin
          ad = a + immx;
          model_mem[ad] = b;
          exp_mem.push_back('{we: 1'b1, addr: ad, wdata: b});
        end
        6'd10: if (a == b) npc = pc + 16'd1 + ins[15:0];
        default: ;
      endcase
      if (wr && dst != 5'd0) begin
        r[dst] = v;
        exp_wb.push_back('{rd: dst, data: v});
      end
      if (op == 6'd11) break;
      pc = npc;
    end
  endtask

  always @(posedge clk) begin
    if (!reset) cyc = 0;
    else cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (dmem_req) req_cycles++;
      if (wb_valid) begin
        wb_cyc.push_back(cyc);
        if (exp_wb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_extra actual rd=%0d data=%0h expected no write", wb_rd, wb_data);
        end else begin
          w = exp_wb.pop_front();
          chk("wb_rd", wb_rd, w.rd);
          chk("wb_data", wb_data, w.data);
        end
      end
    end
  end

  // Data memory: random or forced ack latency, stray acks when idle.
  always @(negedge clk) begin
    if (!reset) begin
      dmem_ack = 1'b0;
      busy = 0;
    end else if (dmem_req) begin
      if (!busy) begin
        busy = 1;
        wait_cnt = (force_delay >= 0) ? force_delay :
                   (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3)));
      end else wait_cnt--;
      if (wait_cnt <= 0) begin
        busy = 0;
        dmem_ack = 1'b1;
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_extra actual addr=%0h expected no access", dmem_addr);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_we", dmem_we, m.we);
          chk("mem_addr", dmem_addr, m.addr);
          if (m.we) begin
            chk("mem_wdata", dmem_wdata, m.wdata);
            dut_mem[dmem_addr] = dmem_wdata;
          end else begin
            dmem_rdata = dut_mem.exists(dmem_addr) ? dut_mem[dmem_addr] : mem_init(dmem_addr);
          end
        end
      end else begin
        dmem_ack = 1'b0;
        dmem_rdata = DW'($urandom);
      end
    end else begin
      busy = 0;
      dmem_ack = ($urandom_range(0, 7) == 0);
      dmem_rdata = DW'($urandom);
    end
  end

  task automatic clear_imem();
    foreach (imem[i]) imem[i] = 32'd0;
  endtask

  task automatic check_reset_state();
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_wb", {wb_valid, wb_rd, wb_data}, 0);
  endtask

  task automatic run_prog(input string tag, input int maxcyc);
    logic [15:0] pc_frz;
    logic [31:0] ret_frz;
    int n;
    reset = 1'b0;
    exp_wb.delete(); exp_mem.delete(); wb_cyc.delete();
    model_mem.delete(); dut_mem.delete();
    run_model();
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;
    req_cycles = 0;
    n = 0;
    while (!halted && n < maxcyc) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual halted=0 expected halted=1 within %0d cycles", tag, maxcyc);
    end
    pc_frz = imem_addr;
    ret_frz = retired;
    repeat (4) @(negedge clk);
    chk({tag, "_retired"}, retired, exp_retired);
    chk({tag, "_retired_frozen"}, retired, ret_frz);
    chk({tag, "_pc_frozen"}, imem_addr, pc_frz);
    chk({tag, "_halted_sticky"}, halted, 1);
    chk({tag, "_wb_left"}, exp_wb.size(), 0);
    chk({tag, "_mem_left"}, exp_mem.size(), 0);
  endtask

  task automatic gen_random(input int n);
    int sel, lim;
    logic [5:0] op;
    logic [4:0] a, b, d;
    logic [15:0] imm;
    clear_imem();
    for (int k = 0; k < n - 1; k++) begin
      sel = $urandom_range(0, 99);
      a = rreg(); b = rreg(); d = rreg(); imm = 16'($urandom);
      if (sel < 8) op = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(12, 63));
      else if (sel < 40) op = 6'($urandom_range(1, 6));
      else if (sel < 55) op = 6'd7;
      else if (sel < 68) op = 6'd8;
      else if (sel < 80) op = 6'd9;
      else begin
        op = 6'd10;
        lim = (n - 2 - k < 3) ? n - 2 - k : 3;
        imm = 16'($urandom_range(0, lim));
        if ($urandom_range(0, 1) == 1) b = a;
      end
      if (op >= 6'd7 && op <= 6'd10) imem[RPCI + k] = {op, a, b, imm};
      else imem[RPCI + k] = {op, a, b, d, 11'($urandom)};
    end
    imem[RPCI + n - 1] = it(11, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=time_limit expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Forwarding chain, results on consecutive cycles.
    clear_imem();
    imem[RPCI+0] = it(7, 1, 0, 5);
    imem[RPCI+1] = it(7, 2, 1, 3);
    imem[RPCI+2] = rt(1, 3, 1, 2);
    imem[RPCI+3] = it(11, 0, 0, 0);
    run_prog("t1", 200);
    chk("t1_nwb", wb_cyc.size(), 3);
    if (wb_cyc.size() >= 3) begin
      chk("t1_cyc0", wb_cyc[0], 3);
      chk("t1_cyc1", wb_cyc[1], 4);
      chk("t1_cyc2", wb_cyc[2], 5);
    end

    // 16-bit wrap and signed compare both ways.
    clear_imem();
    imem[RPCI+0] = it(7, 1, 0, -1);
    imem[RPCI+1] = rt(6, 2, 1, 0);
    imem[RPCI+2] = rt(6, 3, 0, 1);
    imem[RPCI+3] = it(7, 1, 1, 1);
    imem[RPCI+4] = rt(6, 4, 0, 1);
    imem[RPCI+5] = it(11, 0, 0, 0);
    run_prog("t2", 200);

    // Store then load with 3-cycle ack latency each.
    clear_imem();
    imem[RPCI+0] = it(7, 1, 0, 16'h77);
    imem[RPCI+1] = it(9, 1, 0, 4);
    imem[RPCI+2] = it(8, 5, 0, 4);
    imem[RPCI+3] = it(7, 6, 5, 1);
    imem[RPCI+4] = it(11, 0, 0, 0);
    force_delay = 3;
    run_prog("t3", 200);
    force_delay = -1;
    chk("t3_req_cycles", req_cycles, 8);
    chk("t3_nwb", wb_cyc.size(), 3);
    if (wb_cyc.size() >= 3) begin
      chk("t3_cyc_first", wb_cyc[0], 3);
      chk("t3_cyc_load", wb_cyc[1], 11);
      chk("t3_cyc_young", wb_cyc[2], 12);
    end

    // Taken branch flushes a HALT and an ADDI; not-taken branch costs nothing.
    clear_imem();
    imem[RPCI+0] = it(10, 0, 0, 2);
    imem[RPCI+1] = it(11, 0, 0, 0);
    imem[RPCI+2] = it(7, 2, 0, 2);
    imem[RPCI+3] = it(7, 3, 0, 3);
    imem[RPCI+4] = it(10, 0, 3, 5);
    imem[RPCI+5] = it(7, 4, 0, 4);
    imem[RPCI+6] = it(11, 0, 0, 0);
    run_prog("t4", 200);
    chk("t4_nwb", wb_cyc.size(), 2);
    if (wb_cyc.size() >= 2) begin
      chk("t4_cyc_target", wb_cyc[0], 6);
      chk("t4_cyc_nt", wb_cyc[1], 8);
    end

    // HALT after ADD; the instruction after HALT never executes.
    clear_imem();
    imem[RPCI+0] = it(7, 1, 0, 7);
    imem[RPCI+1] = rt(1, 2, 1, 1);
    imem[RPCI+2] = it(11, 0, 0, 0);
    imem[RPCI+3] = it(7, 4, 0, 1);
    run_prog("t5", 200);

    // Reset pulse while a load is waiting for ack.
    clear_imem();
    imem[RPCI+0] = it(7, 1, 0, 3);
    imem[RPCI+1] = it(8, 5, 1, 2);
    imem[RPCI+2] = it(11, 0, 0, 0);
    exp_wb.delete(); exp_mem.delete();
    exp_wb.push_back('{rd: 5'd1, data: 16'd3});
    force_delay = 20;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5r_req_seen", dmem_req, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_state();
    force_delay = -1;

    for (int p = 0; p < 8; p++) begin
      gen_random(40);
      run_prog("rnd", 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
